// File: rtl/acm_cmd_pkg.sv
// Shared command/response codes, FSM state encoding and helpers for the ACM command bridge.
package acm_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_BUS_WR   = 3'd3,
        ST_BUS_RD   = 3'd4,
        ST_SEND     = 3'd5
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_PING  = 8'h50;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    // Saturating increment used for the error counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/acm_cmd_timer.sv
// Shared timeout counter: counts enabled cycles, pulses expire on the TIMEOUT-th one.
module acm_cmd_timer #(
    parameter int TIMEOUT = 24000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    assign expire = enable && (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/acm_cmd_bridge.sv
// Byte-command to register-bus bridge: W addr data / R addr / P, one response byte per command.
module acm_cmd_bridge
    import acm_cmd_pkg::*;
#(
    parameter int TIMEOUT = 24000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_val,
    output logic       rx_rdy,
    output logic [7:0] tx_data,
    output logic       tx_val,
    input  logic       tx_rdy,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ack,
    output logic [7:0] err_cnt,
    output state_t     dbg_state
);

    // Handshake: a byte moves only on rx_val && rx_rdy, a response only on tx_val && tx_rdy.
    state_t     state, state_n;
    logic       is_read, is_read_n;
    logic [7:0] addr_n, wdata_n, tx_data_n, err_n;
    logic       rx_fire, tx_fire, expire, tmr_clear, tmr_en, err_evt;

    assign dbg_state = state;
    assign rx_rdy    = rst_n && (state == ST_IDLE || state == ST_GET_ADDR || state == ST_GET_DATA);
    assign tx_val    = (state == ST_SEND);
    assign bus_we    = (state == ST_BUS_WR);
    assign bus_re    = (state == ST_BUS_RD);
    assign rx_fire   = rx_val && rx_rdy;
    assign tx_fire   = tx_val && tx_rdy;

    assign tmr_en    = (state == ST_GET_ADDR) || (state == ST_GET_DATA) ||
                       (state == ST_BUS_WR)   || (state == ST_BUS_RD);
    assign tmr_clear = rx_fire || (state_n != state);

    acm_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expire (expire)
    );

    always_comb begin
        state_n   = state;
        is_read_n = is_read;
        addr_n    = bus_addr;
        wdata_n   = bus_wdata;
        tx_data_n = tx_data;
        err_evt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_fire) begin
                    case (rx_data)
                        CMD_WRITE: begin is_read_n = 1'b0; state_n = ST_GET_ADDR; end
                        CMD_READ:  begin is_read_n = 1'b1; state_n = ST_GET_ADDR; end
                        CMD_PING:  begin tx_data_n = RSP_ACK; state_n = ST_SEND; end
                        default: begin
                            tx_data_n = RSP_NAK;
                            state_n   = ST_SEND;
                            err_evt   = 1'b1;
                        end
                    endcase
                end
            end
            ST_GET_ADDR: begin
                // An accepted byte beats a timeout landing in the same cycle.
                if (rx_fire) begin
                    addr_n  = rx_data;
                    state_n = is_read ? ST_BUS_RD : ST_GET_DATA;
                end else if (expire) begin
                    state_n = ST_IDLE;
                    err_evt = 1'b1;
                end
            end
            ST_GET_DATA: begin
                if (rx_fire) begin
                    wdata_n = rx_data;
                    state_n = ST_BUS_WR;
                end else if (expire) begin
                    state_n = ST_IDLE;
                    err_evt = 1'b1;
                end
            end
            ST_BUS_WR: begin
                if (bus_ack) begin
                    tx_data_n = RSP_ACK;
                    state_n   = ST_SEND;
                end else if (expire) begin
                    tx_data_n = RSP_NAK;
                    state_n   = ST_SEND;
                    err_evt   = 1'b1;
                end
            end
            ST_BUS_RD: begin
                if (bus_ack) begin
                    tx_data_n = bus_rdata;
                    state_n   = ST_SEND;
                end else if (expire) begin
                    tx_data_n = RSP_NAK;
                    state_n   = ST_SEND;
                    err_evt   = 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_fire) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        err_n = err_evt ? sat_inc(err_cnt) : err_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            is_read   <= 1'b0;
            bus_addr  <= 8'h00;
            bus_wdata <= 8'h00;
            tx_data   <= 8'h00;
            err_cnt   <= 8'h00;
        end else begin
            state     <= state_n;
            is_read   <= is_read_n;
            bus_addr  <= addr_n;
            bus_wdata <= wdata_n;
            tx_data   <= tx_data_n;
            err_cnt   <= err_n;
        end
    end

endmodule

// File: doc/acm_cmd_bridge.md
ACM_CMD_BRIDGE -- requirements
Module: acm_cmd_bridge

Interface
REQ-001 Parameter TIMEOUT, default 24000, cycles allowed between command bytes and for a bus ack (1 ms at 24 MHz).
REQ-002 clk  input  1  user clock; all logic on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rx_data  input  8  command byte from the USB OUT cross-clock stage.
REQ-005 rx_val  input  1  rx_data valid.
REQ-006 rx_rdy  output  1  bridge accepts rx_data.
REQ-007 tx_data  output  8  response byte to the USB IN cross-clock stage.
REQ-008 tx_val  output  1  tx_data valid.
REQ-009 tx_rdy  input  1  downstream accepts tx_data.
REQ-010 bus_addr  output  8  register address.
REQ-011 bus_wdata  output  8  write data.
REQ-012 bus_we  output  1  write strobe, held until ack.
REQ-013 bus_re  output  1  read strobe, held until ack.
REQ-014 bus_rdata  input  8  read data, valid when bus_ack high.
REQ-015 bus_ack  input  1  single-cycle access completion.
REQ-016 err_cnt  output  8  saturating count of timeouts and bad commands.

Function
REQ-017 Byte transfer on rx_val&&rx_rdy; response transfer on tx_val&&tx_rdy; no other event moves data.
REQ-018 States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, SEND.
REQ-019 rx_rdy SHALL be 1 exactly in IDLE, GET_ADDR, GET_DATA; 0 elsewhere.
REQ-020 IDLE: 0x57 'W' -> GET_ADDR (write pending); 0x52 'R' -> GET_ADDR (read pending); 0x50 'P' -> SEND with 0x06; any other byte -> SEND with 0x15, err_cnt+1.
REQ-021 GET_ADDR: accepted byte latched to bus_addr; write -> GET_DATA, read -> BUS_RD.
REQ-022 GET_DATA: accepted byte latched to bus_wdata -> BUS_WR.
REQ-023 BUS_WR/BUS_RD: bus_we/bus_re high from the first cycle in state until the cycle bus_ack is sampled high, inclusive; deasserted the following cycle; never both high.
REQ-024 On bus_ack: write -> SEND 0x06; read -> SEND with bus_rdata captured that cycle.
REQ-025 bus_ack while neither strobe high SHALL be ignored.
REQ-026 SEND: tx_val high, tx_data stable until transfer; then IDLE the next cycle; tx_val low in all other states.
REQ-027 Inter-byte timeout: counter clears on every accepted byte and on entry to GET_ADDR; TIMEOUT cycles in GET_ADDR/GET_DATA without a byte -> IDLE silently, err_cnt+1.
REQ-028 Bus timeout: TIMEOUT cycles in BUS_WR/BUS_RD without ack -> strobe drops, SEND 0x15, err_cnt+1.
REQ-029 SEND has no timeout; back-pressure on tx_rdy holds the state indefinitely.
REQ-030 err_cnt saturates at 0xFF; simultaneous error sources in one cycle count once.
REQ-031 Minimum latency: 'P' accepted at cycle N -> tx_val at N+1; read with same-cycle ack -> tx_val one cycle after ack.

Reset
REQ-032 rst_n low SHALL force, asynchronously: state IDLE, rx_rdy 0 while low, tx_val 0, tx_data 0x00, bus_we 0, bus_re 0, bus_addr 0x00, bus_wdata 0x00, err_cnt 0x00, timeout counter 0.
REQ-033 Reset mid-command or mid-access SHALL abandon it with no response byte; first cycle after release is IDLE with rx_rdy 1.

Structure
REQ-034 Command/response codes (0x57, 0x52, 0x50, 0x06, 0x15) and state encoding SHALL live in shared package acm_cmd_pkg.
REQ-035 Timeout counter SHALL be sub-module acm_cmd_timer (clear, enable, expire pulse), width $clog2(TIMEOUT+1).

Verification
REQ-036 Send 57 10 A5, ack after 3 cycles -> bus_we high 4 cycles, addr 0x10, wdata 0xA5; response 0x06.
REQ-037 Send 52 22, ack same cycle with rdata 0x3C -> bus_re high 1 cycle; response 0x3C.
REQ-038 Send 0x41 -> response 0x15, err_cnt 1; send 50 -> 0x06.
REQ-039 Send 57 10, then idle TIMEOUT cycles -> no response, IDLE, err_cnt+1; next 50 -> 0x06.
REQ-040 Send 52 01, no ack -> bus_re drops after TIMEOUT cycles, response 0x15; tx_rdy low 50 cycles -> tx_val/tx_data held.
REQ-041 Assert rst_n low during BUS_WR -> strobes low immediately, no response, err_cnt 0.
